aes_tcdm_slice: RTL and testbench

AES_TCDM_SLICE -- requirements
Module: aes_tcdm_slice

---
 rtl/aes_tcdm_slice_pkg.sv | 21 ++
 rtl/aes_tcdm_slice_port.sv | 116 +++++++++++
 rtl/aes_tcdm_slice.sv | 63 ++++++
 tb/tb_aes_tcdm_slice.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_tcdm_slice_pkg.sv
// Shared definitions for the TCDM slice: default widths, request layout and
// the per-channel request slot state.
package aes_package;

    localparam int unsigned DEF_AW      = 32;
    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_MAX_OUT = 4;

    typedef struct packed {
        logic [DEF_AW-1:0]   add;
        logic                wen;
        logic [DEF_DW/8-1:0] be;
        logic [DEF_DW-1:0]   data;
    } tcdm_req_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/aes_tcdm_slice_port.sv
// One TCDM channel: single-entry request slot toward memory, in-flight
// credit counter, registered response path and sticky spurious-response flag.
module aes_tcdm_slice_port
    import aes_package::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_req,
    output logic            in_gnt,
    input  logic [AW-1:0]   in_add,
    input  logic            in_wen,
    input  logic [DW/8-1:0] in_be,
    input  logic [DW-1:0]   in_data,
    output logic [DW-1:0]   in_r_data,
    output logic            in_r_valid,
    output logic            out_req,
    input  logic            out_gnt,
    output logic [AW-1:0]   out_add,
    output logic            out_wen,
    output logic [DW/8-1:0] out_be,
    output logic [DW-1:0]   out_data,
    input  logic [DW-1:0]   out_r_data,
    input  logic            out_r_valid,
    output logic            idle_o,
    output logic            err_o
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned KW = CW + 1;

    typedef struct packed {
        logic [AW-1:0]   add;
        logic            wen;
        logic [DW/8-1:0] be;
        logic [DW-1:0]   data;
    } slot_t;

    slot_state_e   state_q, state_d;
    slot_t         slot_q, slot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;
    logic          r_valid_q;
    logic [DW-1:0] r_data_q;

    logic          slot_full;
    logic          mem_hs;
    logic          in_hs;
    logic          rsp_ok;
    logic          rsp_spurious;
    logic [KW-1:0] cnt_next_cap;

    always_comb begin
        slot_full    = (state_q == SLOT_FULL);
        mem_hs       = slot_full & out_gnt;
        rsp_ok       = out_r_valid & (cnt_q != '0);
        rsp_spurious = out_r_valid & (cnt_q == '0);
        // Credits cover both the buffered request and everything already issued.
        cnt_next_cap = KW'(cnt_q) + KW'(slot_full) - KW'(rsp_ok);
        in_gnt       = ~rst_i & (~slot_full | out_gnt) & (cnt_next_cap < KW'(MAX_OUT));
        in_hs        = in_req & in_gnt;

        state_d = state_q;
        slot_d  = slot_q;
        if (in_hs) begin
            state_d     = SLOT_FULL;
            slot_d.add  = in_add;
            slot_d.wen  = in_wen;
            slot_d.be   = in_be;
            slot_d.data = in_data;
        end else if (mem_hs) begin
            state_d = SLOT_EMPTY;
        end

        cnt_d = cnt_q;
        case ({mem_hs, rsp_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= SLOT_EMPTY;
            slot_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            err_q     <= err_q | rsp_spurious;
            r_valid_q <= rsp_ok;
            if (rsp_ok) begin
                r_data_q <= out_r_data;
            end
        end
    end

    assign out_req    = slot_full;
    assign out_add    = slot_q.add;
    assign out_wen    = slot_q.wen;
    assign out_be     = slot_q.be;
    assign out_data   = slot_q.data;
    assign in_r_valid = r_valid_q;
    assign in_r_data  = r_data_q;
    assign idle_o     = ~slot_full & (cnt_q == '0);
    assign err_o      = err_q;

endmodule

// File: rtl/aes_tcdm_slice.sv
// MP independent TCDM channels between an engine and memory, each buffering
// one request and bounding its in-flight transactions to MAX_OUT.
module aes_tcdm_slice
    import aes_package::*;
#(
    parameter int unsigned MP      = 2,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [MP-1:0]            in_req,
    output logic [MP-1:0]            in_gnt,
    input  logic [MP-1:0][AW-1:0]    in_add,
    input  logic [MP-1:0]            in_wen,
    input  logic [MP-1:0][DW/8-1:0]  in_be,
    input  logic [MP-1:0][DW-1:0]    in_data,
    output logic [MP-1:0][DW-1:0]    in_r_data,
    output logic [MP-1:0]            in_r_valid,
    output logic [MP-1:0]            out_req,
    input  logic [MP-1:0]            out_gnt,
    output logic [MP-1:0][AW-1:0]    out_add,
    output logic [MP-1:0]            out_wen,
    output logic [MP-1:0][DW/8-1:0]  out_be,
    output logic [MP-1:0][DW-1:0]    out_data,
    input  logic [MP-1:0][DW-1:0]    out_r_data,
    input  logic [MP-1:0]            out_r_valid,
    output logic [MP-1:0]            idle_o,
    output logic [MP-1:0]            err_o
);

    genvar ii;
    for (ii = 0; ii < MP; ii++) begin : g_ch
        aes_tcdm_slice_port #(
            .AW      (AW),
            .DW      (DW),
            .MAX_OUT (MAX_OUT)
        ) u_port (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .in_req      (in_req[ii]),
            .in_gnt      (in_gnt[ii]),
            .in_add      (in_add[ii]),
            .in_wen      (in_wen[ii]),
            .in_be       (in_be[ii]),
            .in_data     (in_data[ii]),
            .in_r_data   (in_r_data[ii]),
            .in_r_valid  (in_r_valid[ii]),
            .out_req     (out_req[ii]),
            .out_gnt     (out_gnt[ii]),
            .out_add     (out_add[ii]),
            .out_wen     (out_wen[ii]),
            .out_be      (out_be[ii]),
            .out_data    (out_data[ii]),
            .out_r_data  (out_r_data[ii]),
            .out_r_valid (out_r_valid[ii]),
            .idle_o      (idle_o[ii]),
            .err_o       (err_o[ii])
        );
    end

endmodule

// File: tb/tb_aes_tcdm_slice.sv
// Directed bench for aes_tcdm_slice: stimulus pushes expected responses into
// per-channel queues that a negedge monitor pops against in_r_valid/in_r_data.
module tb_aes_tcdm_slice;
    import aes_package::*;

    localparam int unsigned MP      = 2;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned MAX_OUT = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    logic [MP-1:0]           in_req, in_gnt, in_wen, in_r_valid;
    logic [MP-1:0]           out_req, out_gnt, out_wen, out_r_valid;
    logic [MP-1:0]           idle_o, err_o;
    logic [MP-1:0][AW-1:0]   in_add, out_add;
    logic [MP-1:0][DW/8-1:0] in_be, out_be;
    logic [MP-1:0][DW-1:0]   in_data, in_r_data, out_data, out_r_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    aes_tcdm_slice #(
        .MP      (MP),
        .AW      (AW),
        .DW      (DW),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_req      (in_req),
        .in_gnt      (in_gnt),
        .in_add      (in_add),
        .in_wen      (in_wen),
        .in_be       (in_be),
        .in_data     (in_data),
        .in_r_data   (in_r_data),
        .in_r_valid  (in_r_valid),
        .out_req     (out_req),
        .out_gnt     (out_gnt),
        .out_add     (out_add),
        .out_wen     (out_wen),
        .out_be      (out_be),
        .out_data    (out_data),
        .out_r_data  (out_r_data),
        .out_r_valid (out_r_valid),
        .idle_o      (idle_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Response monitor
    always @(negedge clk_i) begin
        if (in_r_valid[0] === 1'b1) begin
            if (exp_q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected_ch0: got 0x%0h expected no response", in_r_data[0]);
            end else begin
                chk("rsp_data_ch0", 64'(in_r_data[0]), 64'(exp_q0.pop_front()));
            end
        end
        if (in_r_valid[1] === 1'b1) begin
            if (exp_q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected_ch1: got 0x%0h expected no response", in_r_data[1]);
            end else begin
                chk("rsp_data_ch1", 64'(in_r_data[1]), 64'(exp_q1.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g1, g2, gnow;
        in_req      = '0;
        in_wen      = '0;
        in_add      = '0;
        in_be       = '1;
        in_data     = '0;
        out_gnt     = '0;
        out_r_valid = '0;
        out_r_data  = '0;

        // Reset state; grant must stay low while reset is asserted
        repeat (2) @(posedge clk_i);
        #1;
        in_req[0] = 1'b1;
        #1;
        chk("gnt_during_reset", 64'(in_gnt[0]), 64'd0);
        chk("reset_idle", 64'(idle_o), 64'h3);
        chk("reset_err", 64'(err_o), 64'h0);
        chk("reset_out_req", 64'(out_req), 64'h0);
        chk("reset_r_valid", 64'(in_r_valid), 64'h0);
        chk("reset_r_data0", 64'(in_r_data[0]), 64'h0);
        chk("reset_out_add0", 64'(out_add[0]), 64'h0);
        in_req[0] = 1'b0;
        rst_i     = 1'b0;
        step();

        // Single read
        in_req[0] = 1'b1; in_wen[0] = 1'b1; in_add[0] = 32'h100; out_gnt[0] = 1'b1;
        #1;
        chk("t1_gnt", 64'(in_gnt[0]), 64'd1);
        step();
        in_req[0] = 1'b0;
        #1;
        chk("t1_out_req", 64'(out_req[0]), 64'd1);
        chk("t1_out_add", 64'(out_add[0]), 64'h100);
        chk("t1_out_wen", 64'(out_wen[0]), 64'd1);
        step();
        out_gnt[0] = 1'b0;
        #1;
        chk("t1_slot_drained", 64'(out_req[0]), 64'd0);
        chk("t1_busy", 64'(idle_o[0]), 64'd0);
        step();
        out_r_valid[0] = 1'b1; out_r_data[0] = 32'hDEADBEEF;
        exp_q0.push_back(32'hDEADBEEF);
        step();
        out_r_valid[0] = 1'b0; out_r_data[0] = '0;
        #1;
        chk("t1_r_valid", 64'(in_r_valid[0]), 64'd1);
        chk("t1_r_data", 64'(in_r_data[0]), 64'hDEADBEEF);
        step();
        chk("t1_idle", 64'(idle_o[0]), 64'd1);
        chk("t1_r_valid_low", 64'(in_r_valid[0]), 64'd0);
        chk("t1_r_data_hold", 64'(in_r_data[0]), 64'hDEADBEEF);

        // Back-pressure
        in_req[0] = 1'b1; in_wen[0] = 1'b0; in_add[0] = 32'h200; in_data[0] = 32'h11;
        #1;
        chk("t2_gnt_first", 64'(in_gnt[0]), 64'd1);
        step();
        in_add[0] = 32'h204; in_data[0] = 32'h22;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_bp_gnt", 64'(in_gnt[0]), 64'd0);
            chk("t2_bp_add", 64'(out_add[0]), 64'h200);
            chk("t2_bp_data", 64'(out_data[0]), 64'h11);
            step();
        end
        out_gnt[0] = 1'b1;
        #1;
        chk("t2_gnt_release", 64'(in_gnt[0]), 64'd1);
        step();
        in_req[0] = 1'b0;
        #1;
        chk("t2_next_add", 64'(out_add[0]), 64'h204);
        chk("t2_next_data", 64'(out_data[0]), 64'h22);
        step();
        out_gnt[0] = 1'b0;
        out_r_valid[0] = 1'b1; out_r_data[0] = 32'hA1; exp_q0.push_back(32'hA1);
        step();
        out_r_data[0] = 32'hA2; exp_q0.push_back(32'hA2);
        step();
        out_r_valid[0] = 1'b0;
        step();
        chk("t2_idle", 64'(idle_o[0]), 64'd1);

        // Credit limit
        in_req[0] = 1'b1; in_wen[0] = 1'b1; out_gnt[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_add[0] = 32'h300 + 32'(4 * i);
            #1;
            chk("t3_gnt_credit", 64'(in_gnt[0]), 64'd1);
            step();
        end
        in_add[0] = 32'h310;
        #1;
        chk("t3_gnt_full", 64'(in_gnt[0]), 64'd0);
        step();
        chk("t3_gnt_full2", 64'(in_gnt[0]), 64'd0);
        chk("t3_cnt_max", 64'(dut.g_ch[0].u_port.cnt_q), 64'd4);
        out_r_valid[0] = 1'b1; out_r_data[0] = 32'hC0; exp_q0.push_back(32'hC0);
        #1;
        chk("t3_gnt_on_rsp", 64'(in_gnt[0]), 64'd1);
        step();
        in_req[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            out_r_data[0] = 32'hC0 + 32'(i);
            exp_q0.push_back(32'hC0 + 32'(i));
            step();
        end
        out_r_valid[0] = 1'b0; out_gnt[0] = 1'b0;
        step();
        chk("t3_idle", 64'(idle_o[0]), 64'd1);
        chk("t3_err", 64'(err_o[0]), 64'd0);

        // Streaming, memory answers two cycles after each grant
        g1 = 1'b0; g2 = 1'b0;
        in_req[0] = 1'b1; in_wen[0] = 1'b1; out_gnt[0] = 1'b1;
        for (int t = 0; t < 16; t++) begin
            in_req[0]      = (t < 12);
            in_add[0]      = 32'h400 + 32'(4 * t);
            out_r_valid[0] = g2;
            out_r_data[0]  = 32'h5000 + 32'(t);
            if (g2) exp_q0.push_back(32'h5000 + 32'(t));
            #1;
            if (t >= 3 && t < 12) begin
                chk("t4_stream_gnt", 64'(in_gnt[0]), 64'd1);
                chk("t4_stream_out_req", 64'(out_req[0]), 64'd1);
                chk("t4_stream_cnt", 64'(dut.g_ch[0].u_port.cnt_q), 64'd2);
            end
            gnow = out_req[0] & out_gnt[0];
            step();
            g2 = g1;
            g1 = gnow;
        end
        out_r_valid[0] = 1'b0; out_gnt[0] = 1'b0;
        #1;
        chk("t4_err", 64'(err_o[0]), 64'd0);
        chk("t4_idle", 64'(idle_o[0]), 64'd1);

        // Spurious response on channel 1
        out_r_valid[1] = 1'b1; out_r_data[1] = 32'hBAD;
        step();
        out_r_valid[1] = 1'b0;
        #1;
        chk("t5_err_set", 64'(err_o[1]), 64'd1);
        chk("t5_no_fwd", 64'(in_r_valid[1]), 64'd0);
        chk("t5_idle", 64'(idle_o[1]), 64'd1);
        repeat (3) step();
        chk("t5_err_sticky", 64'(err_o), 64'h2);

        // Reset mid-operation: channel 0 slot full with three in flight
        in_req[0] = 1'b1; in_wen[0] = 1'b1; out_gnt[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_add[0] = 32'h500 + 32'(4 * i);
            step();
        end
        in_req[0] = 1'b0; out_gnt[0] = 1'b0;
        #1;
        chk("t6_pre_full", 64'(out_req[0]), 64'd1);
        chk("t6_pre_cnt", 64'(dut.g_ch[0].u_port.cnt_q), 64'd3);
        rst_i = 1'b1; in_req[1] = 1'b1; in_add[1] = 32'h5FC;
        #1;
        chk("t6_gnt_in_rst", 64'(in_gnt[1]), 64'd0);
        step();
        rst_i = 1'b0; in_req[1] = 1'b0;
        out_r_valid[0] = 1'b1; out_r_data[0] = 32'h77;
        #1;
        chk("t6_out_req", 64'(out_req), 64'h0);
        chk("t6_idle", 64'(idle_o), 64'h3);
        chk("t6_err_clr", 64'(err_o), 64'h0);
        step();
        out_r_valid[0] = 1'b0;
        #1;
        chk("t6_err_after_rst", 64'(err_o), 64'h1);
        chk("t6_no_fwd", 64'(in_r_valid[0]), 64'd0);
        in_req[1] = 1'b1; in_wen[1] = 1'b1; in_add[1] = 32'h600; out_gnt[1] = 1'b1;
        #1;
        chk("t6_ch1_gnt", 64'(in_gnt[1]), 64'd1);
        step();
        in_req[1] = 1'b0;
        #1;
        chk("t6_ch1_add", 64'(out_add[1]), 64'h600);
        step();
        out_gnt[1] = 1'b0;
        out_r_valid[1] = 1'b1; out_r_data[1] = 32'h1234; exp_q1.push_back(32'h1234);
        step();
        out_r_valid[1] = 1'b0;
        step();
        chk("t6_ch1_idle", 64'(idle_o[1]), 64'd1);
        chk("t6_err_final", 64'(err_o), 64'h1);

        step();
        chk("q_empty_ch0", 64'(exp_q0.size()), 64'd0);
        chk("q_empty_ch1", 64'(exp_q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
